// File: rtl/wb_pipe_stage_if.sv
// MEM->WB boundary bundle: M-stage inputs, stall/flush control, hazard queries
// and the W-stage results.
interface wb_pipe_stage_if #(
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5
);
  logic                              StallW;
  logic                              FlushW;
  logic                              ValidM;
  logic                              RegWriteM;
  logic [1:0]                        ResultSrcM;
  logic [DATA_WIDTH-1:0]             ALUResultM;
  logic [DATA_WIDTH-1:0]             ReadDataM;
  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM;
  logic [DATA_WIDTH-1:0]             PCPlus4M;
  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1Q;
  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2Q;

  logic                              ValidW;
  logic                              RegWriteW;
  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW;
  logic [DATA_WIDTH-1:0]             ResultW;
  logic [DATA_WIDTH-1:0]             ALUResultW;
  logic [DATA_WIDTH-1:0]             ReadDataW;
  logic [DATA_WIDTH-1:0]             PCPlus4W;
  logic                              Rs1PendW;
  logic                              Rs2PendW;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, ResultSrcM, ALUResultM,
           ReadDataM, RdM, PCPlus4M, Rs1Q, Rs2Q,
    input  ValidW, RegWriteW, RdW, ResultW, ALUResultW, ReadDataW,
           PCPlus4W, Rs1PendW, Rs2PendW
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, ResultSrcM, ALUResultM,
           ReadDataM, RdM, PCPlus4M, Rs1Q, Rs2Q,
    output ValidW, RegWriteW, RdW, ResultW, ALUResultW, ReadDataW,
           PCPlus4W, Rs1PendW, Rs2PendW
  );
endinterface

// File: rtl/wb_pipe_stage.sv
// Parametrised MEM->WB pipeline register (1..4 stages) with stall, flush,
// per-stage valid tracking, writeback result mux and in-flight write lookup.
module wb_pipe_stage #(
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned STAGES                 = 1
) (
  input logic            clk,
  input logic            rst,
  wb_pipe_stage_if.slave bus
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("wb_pipe_stage: STAGES must be in 1..4");
  end

  typedef struct packed {
    logic                              valid;
    logic                              reg_write;
    logic [1:0]                        result_src;
    logic [DATA_WIDTH-1:0]             alu_result;
    logic [DATA_WIDTH-1:0]             read_data;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]             pc_plus4;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t entry;
  stage_t last;

  always_comb begin
    entry            = '0;
    entry.valid      = bus.ValidM;
    entry.reg_write  = bus.RegWriteM;
    entry.result_src = bus.ResultSrcM;
    entry.alu_result = bus.ALUResultM;
    entry.read_data  = bus.ReadDataM;
    entry.rd         = bus.RdM;
    entry.pc_plus4   = bus.PCPlus4M;
  end

  // Flush only rewrites the entry stage; later stages still obey StallW.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      if (bus.FlushW) begin
        stage_q[0] <= '0;
      end else if (!bus.StallW) begin
        stage_q[0] <= entry;
      end
      if (!bus.StallW) begin
        for (int unsigned i = 1; i < STAGES; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end
  end

  assign last = stage_q[STAGES-1];

  always_comb begin
    bus.ValidW     = last.valid;
    bus.RegWriteW  = last.valid & last.reg_write & (last.rd != '0);
    bus.RdW        = last.rd;
    bus.ALUResultW = last.alu_result;
    bus.ReadDataW  = last.read_data;
    bus.PCPlus4W   = last.pc_plus4;
    bus.ResultW    = '0;
    case (last.result_src)
      2'b00:   bus.ResultW = last.alu_result;
      2'b01:   bus.ResultW = last.read_data;
      2'b10:   bus.ResultW = last.pc_plus4;
      default: bus.ResultW = '0;
    endcase
  end

  // Every stage, including the output one, counts as a pending writer.
  always_comb begin
    logic hit1;
    logic hit2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (stage_q[i].valid && stage_q[i].reg_write) begin
        if (stage_q[i].rd == bus.Rs1Q) hit1 = 1'b1;
        if (stage_q[i].rd == bus.Rs2Q) hit2 = 1'b1;
      end
    end
    bus.Rs1PendW = hit1 & (bus.Rs1Q != '0);
    bus.Rs2PendW = hit2 & (bus.Rs2Q != '0);
  end

endmodule
